debounce_sync_rstn: RTL
=======================

# debounce_sync_rstn

Input-conditioning stage placed in front of the synchronous-reset D flip-flop stages. It takes a raw, asynchronous, bouncing switch or level input and synchronises it to `clk` through two flops. It accepts a new level only after that level has been stable for `STABLE_CYCLES` consecutive samples. It then drives the clean level (`q`/`q_not`) plus single-cycle edge pulses (`rise`/`fall`) into downstream flip-flop `d` inputs.

## Interface
- `STABLE_CYCLES`, default 4: consecutive synchronised samples required to accept a new level; legal range 2..255.
- `CNT_W`, default `$clog2(STABLE_CYCLES+1)`: stability-counter width; derived, not overridden.
- `clk`, input, 1: single clock, rising edge; nominal period 1 us (timescale 1us/1ns).
- `reset_n`, input, 1: reset, synchronous, active-low; sampled only on rising `clk`.
- `d_raw`, input, 1: raw asynchronous input, may bounce or glitch.
- `q`, output, 1: debounced level, registered.
- `q_not`, output, 1: always `~q`, registered alongside `q`.
- `rise`, output, 1: one-cycle pulse on the cycle `q` first reads 1.
- `fall`, output, 1: one-cycle pulse on the cycle `q` first reads 0.
- `busy`, output, 1: high while a candidate level change is being qualified (WAIT states).

## Operation
- **Synchroniser:** `sync1 <= d_raw`, `sync2 <= sync1`. The FSM sees only `sync2`.
- **FSM states:** `LOW`, `WAIT_H`, `HIGH`, `WAIT_L`; 2-bit encoding, free choice.
- **LOW:**
  - If `sync2==1`, go to `WAIT_H` with `cnt<=1`.
  - Otherwise stay, with `cnt<=0`.
- **WAIT_H:**
  - If `sync2==0`, return to `LOW` with `cnt<=0`. This is a glitch: no output change, no pulse.
  - Else if `cnt==STABLE_CYCLES-1`, go to `HIGH` with `q<=1`, `q_not<=0`, `rise<=1`, `cnt<=0`.
  - Else `cnt<=cnt+1`.
- **HIGH / WAIT_L:** mirror images of LOW / WAIT_H with polarity swapped; the exit from `WAIT_L` asserts `fall`.
- **Pulses:** `rise` and `fall` are deasserted on every cycle other than the acceptance cycle. They are never high together.
- **`busy`:** is 1 exactly when the state is `WAIT_H` or `WAIT_L`.
- **Counter:** `cnt` never exceeds `STABLE_CYCLES-1` and never wraps. It is cleared on every return to a stable state.
- **Reset:** reset has priority over all logic. On any rising edge with `reset_n==0`:
  - `sync1`, `sync2`, `cnt` are 0 and the state is `LOW`.
  - `q=0`, `q_not=1`, `rise=0`, `fall=0`, `busy=0`.
- **Reset mid-operation:** reset during `HIGH` or `WAIT_*` forces `q` to 0 with no `fall` pulse. Any qualification in progress is discarded.

## Timing
- **Acceptance latency:** `d_raw` changes before edge k and then holds. `sync1` updates at k, `sync2` at k+1, `WAIT_*` is entered at k+2 (sample 1). `q` changes, and `rise`/`fall` assert, at edge k+1+`STABLE_CYCLES`. This is 5 edges for the default value.
- **Pulse width:** `rise`/`fall` deassert at the following edge; each pulse is exactly 1 clock wide.
- **Glitch rejection:** any excursion of `sync2` shorter than `STABLE_CYCLES` samples produces no change on `q`, `rise` or `fall`. `busy` is high for the excursion length.
- **Back-to-back excursions:** a new change while the block is in a stable state starts a fresh count from 1. There is no carry-over from earlier excursions.
- **Reset release:** reset is released with `d_raw` already 1, and r is the first edge with `reset_n==1`. `q` rises at edge r+1+`STABLE_CYCLES`, with a `rise` pulse.
- **Outputs:** all outputs are registered. There is no combinational path from `d_raw` or `reset_n` to any output.

## Test plan
- **Reset values:** hold `reset_n=0` for 3 cycles with `d_raw` toggling → `q=0`, `q_not=1`, `rise=fall=busy=0` throughout.
- **Clean rise:** `STABLE_CYCLES=4`; release reset, then set `d_raw=1` before edge k and hold → `q` goes 1 at edge k+5, `rise` is high for exactly 1 cycle, `busy` is high over edges k+2..k+4.
- **Glitch rejection:** with `q=0`, pulse `d_raw` high for 2 cycles, then low → `q` stays 0, no `rise`, `busy` is high for 2 cycles then 0.
- **Bounce then settle:** toggle `d_raw` at random 1–3 cycle intervals 5 times, then hold 1 → exactly one `rise`, occurring 5 edges after the final change. Repeat for the falling direction → exactly one `fall`.
- **Reset mid-operation:**
  - Assert `reset_n=0` in `WAIT_H` → count is discarded, `q` stays 0.
  - Assert `reset_n=0` in `HIGH` → `q` drops to 0 at the reset edge with no `fall` pulse.
  - After release with `d_raw=1` → `q` is 1 at r+5.
- **Parameter corner:** `STABLE_CYCLES=2` with a 1-cycle excursion → rejected. A 2-cycle hold → accepted at edge k+3.

Source files
------------

// File: rtl/debounce_sync_rstn.sv
// debounce_sync_rstn
//   Conditions a raw, bouncing, asynchronous level input for downstream
//   synchronous-reset flip-flops. The input passes through a two-flop
//   synchroniser; a four-state FSM then accepts a new level only after
//   STABLE_CYCLES consecutive synchronised samples agree on it.
//
// Parameters
//   STABLE_CYCLES : consecutive samples needed to accept a level (2..255)
//   CNT_W         : stability counter width, derived from STABLE_CYCLES
//
// Ports
//   clk     : clock, rising edge
//   reset_n : synchronous active-low reset, priority over everything
//   d_raw   : raw asynchronous input
//   q       : debounced level (registered)
//   q_not   : ~q (registered alongside q)
//   rise    : one-cycle pulse on the cycle q first reads 1
//   fall    : one-cycle pulse on the cycle q first reads 0
//   busy    : high while a candidate level change is being qualified
`timescale 1us/1ns

module debounce_sync_rstn #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_raw,
    output logic q,
    output logic q_not,
    output logic rise,
    output logic fall,
    output logic busy
);

    typedef enum logic [1:0] {
        LOW    = 2'b00,
        WAIT_H = 2'b01,
        HIGH   = 2'b10,
        WAIT_L = 2'b11
    } state_t;

    // Counter value on the sample that completes qualification.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1, sync2;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             q_nxt, rise_nxt, fall_nxt, busy_nxt;

    // Registers: synchroniser, FSM state, counter and all outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            state <= LOW;
            cnt   <= '0;
            q     <= 1'b0;
            q_not <= 1'b1;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            sync1 <= d_raw;
            sync2 <= sync1;
            state <= state_nxt;
            cnt   <= cnt_nxt;
            q     <= q_nxt;
            q_not <= ~q_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
            busy  <= busy_nxt;
        end
    end

    // Next-state logic. The counter defaults to zero so every return to a
    // stable state clears it; it only advances inside a WAIT state and stops
    // at CNT_LAST, so it can never wrap.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        q_nxt     = q;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;

        case (state)
            LOW: begin
                if (sync2) begin
                    state_nxt = WAIT_H;
                    cnt_nxt   = CNT_ONE;
                end
            end
            WAIT_H: begin
                if (!sync2) begin
                    state_nxt = LOW;            // glitch: drop silently
                end else if (cnt == CNT_LAST) begin
                    state_nxt = HIGH;
                    q_nxt     = 1'b1;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end
            HIGH: begin
                if (!sync2) begin
                    state_nxt = WAIT_L;
                    cnt_nxt   = CNT_ONE;
                end
            end
            WAIT_L: begin
                if (sync2) begin
                    state_nxt = HIGH;           // glitch: drop silently
                end else if (cnt == CNT_LAST) begin
                    state_nxt = LOW;
                    q_nxt     = 1'b0;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = LOW;
            end
        endcase

        // busy is registered from the next state so it tracks the state
        // register exactly while still being a flop output.
        busy_nxt = (state_nxt == WAIT_H) || (state_nxt == WAIT_L);
    end

endmodule
